interrupt_control: RTL and testbench
====================================

// Module: interrupt_control
// PURPOSE
//  Upstream of the CPU state machine: owns the PDP-8/e interrupt system and drives its int_ena, int_inh and int_req inputs.
//  Decodes the interrupt IOTs (6000-6007) and the KM8E field IOTs (62xx) plus JMP/JMS.
//  Implements the delayed ION/RTF enable and synchronises asynchronous device request lines.
//  Clears the enable when the state machine reports int_in_prog.
// PARAMETERS
//  N_DEV    8   number of device interrupt request lines (1..32)
//  SYNC_FF  2   synchroniser depth on irq lines (>=2)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-low reset
//  instruction  in   12  current IR contents [0:11], bit 0 = MSB
//  iot_strobe   in   1   1-cycle pulse: IOT in 'instruction' is executing this cycle
//  instr_done   in   1   1-cycle pulse: current instruction completes (last cycle before next F0)
//  jmp_exec     in   1   1-cycle pulse: JMP or JMS executed
//  ac_link_in   in   1   link bit of AC for RTF (restores ION from AC bit 0 path: 1 = enable)
//  int_in_prog  in   1   state machine has entered interrupt entry (forced JMS 0)
//  irq          in   N_DEV  device requests, asynchronous, active-high, wired-OR
//  int_ena      out  1   interrupt enable (ION flip-flop, delayed)
//  int_inh      out  1   interrupt inhibit (set by CIF/CDIF, cleared by JMP/JMS)
//  int_req      out  1   synchronised OR of irq
//  skip         out  1   1-cycle skip request, valid with iot_strobe
//  caf          out  1   1-cycle pulse on CAF (6007) for other devices
// BEHAVIOUR
//  Reset (async, reset==0): int_ena=0, int_inh=0, int_req=0, skip=0, caf=0, FSM=OFF, synchronisers=0.
//  Enable FSM, states OFF, ARM, DLY, ON; int_ena=1 only in ON:
//   - OFF/ON + iot_strobe ION(6001) or RTF(6005 with ac_link_in=1) -> ARM.
//   - ARM + instr_done -> DLY (the ION/RTF itself completes).
//   - DLY + instr_done -> ON (instruction after ION completes; enable visible next cycle).
//   - any state + IOF(6002), SKON(6000), CAF(6007) or int_in_prog -> OFF, same edge.
//   - RTF with ac_link_in=0 -> OFF.
//   - Priority when simultaneous: int_in_prog > CAF > IOF/SKON > ION/RTF > instr_done.
//  Skip (combinational decode registered to 1 cycle, asserted the cycle after iot_strobe):
//   - SKON: skip=1 if int_ena was 1 before the strobe (then FSM->OFF).
//   - SRQ(6003): skip=int_req.
//   - SGT(6006): skip=0 (no GT flag in this block).
//   - all other decoded IOTs: skip=0.
//  Inhibit:
//   - set on iot_strobe with instruction[0:5]=62 (octal) and bit 10 set (CIF 62N2, CDIF 62N3).
//   - cleared on jmp_exec or CAF; set beats clear if same cycle (never coincide in legal flow).
//  int_req: OR of irq after SYNC_FF flops; latency SYNC_FF cycles assert and deassert.
//  caf: 1-cycle pulse the cycle after iot_strobe with 6007; also clears int_inh.
//  Non-matching IOTs (device code != 00 or 2x) ignored entirely.
//  Reset asserted mid-ARM/DLY returns to OFF; no pending enable survives reset.
//  No masking here: int_ena/int_inh gating is the state machine's job.
// TESTING
//  1 Reset low 100 ns then high: all outputs 0; irq=8'h01 -> int_req=1 after exactly SYNC_FF clocks.
//  2 ION (6001) strobe, instr_done x1 -> int_ena still 0; second instr_done -> int_ena=1 next cycle.
//  3 int_ena=1, SKON (6000) -> skip=1 for 1 cycle and int_ena=0; repeat SKON -> skip=0.
//  4 ION armed (ARM), IOF (6002) before instr_done -> int_ena never asserts; int_in_prog in ON -> 0.
//  5 CIF 6212 -> int_inh=1; instr_done without jmp_exec keeps 1; jmp_exec -> int_inh=0.
//  6 CAF 6007 with int_ena=1, int_inh=1 -> caf pulse, int_ena=0, int_inh=0; reset during DLY -> OFF.

Source files
------------

// File: rtl/interrupt_control.sv
// PDP-8/e interrupt system: ION/IOF/SKON/SRQ/CAF decode, delayed enable FSM,
// KM8E inhibit flag and synchronised device request OR.
module interrupt_control #(
   parameter int N_DEV   = 8,
   parameter int SYNC_FF = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [0:11]      instruction,
   input  logic             iot_strobe,
   input  logic             instr_done,
   input  logic             jmp_exec,
   input  logic             ac_link_in,
   input  logic             int_in_prog,
   input  logic [N_DEV-1:0] irq,
   output logic             int_ena,
   output logic             int_inh,
   output logic             int_req,
   output logic             skip,
   output logic             caf
);

   typedef enum logic [1:0] {
      ST_OFF = 2'd0,
      ST_ARM = 2'd1,
      ST_DLY = 2'd2,
      ST_ON  = 2'd3
   } ena_state_t;

   ena_state_t             state;
   logic [SYNC_FF-1:0][N_DEV-1:0] sync_q;

   // Instruction decode; bit 0 of the IR is the MSB, so octal digits read left to right.
   logic       is_int_iot;
   logic       is_km8e_iot;
   logic [2:0] op;
   logic       skon_dec, ion_dec, iof_dec, srq_dec, rtf_dec, caf_dec, cif_dec;

   always_comb begin
      is_int_iot  = (instruction[0:8] == 9'o600);
      is_km8e_iot = (instruction[0:5] == 6'o62);
      op          = instruction[9:11];
      skon_dec    = iot_strobe && is_int_iot && (op == 3'o0);
      ion_dec     = iot_strobe && is_int_iot && (op == 3'o1);
      iof_dec     = iot_strobe && is_int_iot && (op == 3'o2);
      srq_dec     = iot_strobe && is_int_iot && (op == 3'o3);
      rtf_dec     = iot_strobe && is_int_iot && (op == 3'o5);
      caf_dec     = iot_strobe && is_int_iot && (op == 3'o7);
      cif_dec     = iot_strobe && is_km8e_iot && instruction[10];
   end

   // Enable FSM; int_ena is registered alongside the state so it is high only in ON.
   // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_OFF;
         int_ena <= 1'b0;
      end else if (int_in_prog || caf_dec || iof_dec || skon_dec) begin
         state   <= ST_OFF;
         int_ena <= 1'b0;
      end else if (rtf_dec && !ac_link_in) begin
         state   <= ST_OFF;
         int_ena <= 1'b0;
      end else if ((ion_dec || rtf_dec) && (state == ST_OFF || state == ST_ON)) begin
         state   <= ST_ARM;
         int_ena <= 1'b0;
      end else if (instr_done) begin
         case (state)
            ST_ARM: begin
               state   <= ST_DLY;
               int_ena <= 1'b0;
            end
            ST_DLY: begin
               state   <= ST_ON;
               int_ena <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Skip and CAF are one-cycle pulses in the cycle after the strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         skip <= 1'b0;
         caf  <= 1'b0;
      end else begin
         skip <= (skon_dec && int_ena) || (srq_dec && int_req);
         caf  <= caf_dec;
      end
   end

   // Set wins over clear when CIF/CDIF and JMP/CAF land together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         int_inh <= 1'b0;
      end else if (cif_dec) begin
         int_inh <= 1'b1;
      end else if (jmp_exec || caf_dec) begin
         int_inh <= 1'b0;
      end
   end

   // Each request line is synchronised separately before the OR so glitches cannot merge.
   // NOTE: the synchroniser array is reset so int_req is a clean 0 straight out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_FF-2:0], irq};
      end
   end

   assign int_req = |sync_q[SYNC_FF-1];

endmodule

// File: tb/tb_interrupt_control.sv
// Directed, table-driven bench for interrupt_control with hand-written
// sequences for synchroniser latency, SRQ and reset during the enable delay.
module tb_interrupt_control;

   localparam int N_DEV   = 8;
   localparam int SYNC_FF = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic [11:0]      instruction;
   logic             iot_strobe, instr_done, jmp_exec, ac_link_in, int_in_prog;
   logic [N_DEV-1:0] irq;
   logic             int_ena, int_inh, int_req, skip, caf;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   interrupt_control #(.N_DEV(N_DEV), .SYNC_FF(SYNC_FF)) dut (
      .clk         (clk),
      .reset       (reset),
      .instruction (instruction),
      .iot_strobe  (iot_strobe),
      .instr_done  (instr_done),
      .jmp_exec    (jmp_exec),
      .ac_link_in  (ac_link_in),
      .int_in_prog (int_in_prog),
      .irq         (irq),
      .int_ena     (int_ena),
      .int_inh     (int_inh),
      .int_req     (int_req),
      .skip        (skip),
      .caf         (caf)
   );

   typedef struct {
      string      name;
      logic [11:0] instr;
      logic       strobe, done, jmp, link, inprog;
      logic       ena, inh, skp, cf;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      instruction = 12'o7000;
      iot_strobe  = 1'b0;
      instr_done  = 1'b0;
      jmp_exec    = 1'b0;
      ac_link_in  = 1'b0;
      int_in_prog = 1'b0;
   endtask

   task automatic add(input string n, input logic [11:0] i, input logic s, input logic d,
                      input logic j, input logic l, input logic p, input logic e,
                      input logic h, input logic k, input logic c);
      vec_t v;
      v.name = n; v.instr = i; v.strobe = s; v.done = d; v.jmp = j; v.link = l;
      v.inprog = p; v.ena = e; v.inh = h; v.skp = k; v.cf = c;
      vecs.push_back(v);
   endtask

   initial begin
      //   name          instr    stb done jmp link prog | ena inh skip caf
      add("ion",         12'o6001, 1, 0, 0, 0, 0,   0, 0, 0, 0);
      add("ion_done1",   12'o7000, 0, 1, 0, 0, 0,   0, 0, 0, 0);
      add("ion_done2",   12'o7000, 0, 1, 0, 0, 0,   1, 0, 0, 0);
      add("skon_on",     12'o6000, 1, 0, 0, 0, 0,   0, 0, 1, 0);
      add("skon_off",    12'o6000, 1, 0, 0, 0, 0,   0, 0, 0, 0);
      add("ion_arm",     12'o6001, 1, 0, 0, 0, 0,   0, 0, 0, 0);
      add("iof_in_arm",  12'o6002, 1, 0, 0, 0, 0,   0, 0, 0, 0);
      add("iof_done1",   12'o7000, 0, 1, 0, 0, 0,   0, 0, 0, 0);
      add("iof_done2",   12'o7000, 0, 1, 0, 0, 0,   0, 0, 0, 0);
      add("ion2",        12'o6001, 1, 0, 0, 0, 0,   0, 0, 0, 0);
      add("ion2_done1",  12'o7000, 0, 1, 0, 0, 0,   0, 0, 0, 0);
      add("ion2_done2",  12'o7000, 0, 1, 0, 0, 0,   1, 0, 0, 0);
      add("srq_noreq",   12'o6003, 1, 0, 0, 0, 0,   1, 0, 0, 0);
      add("int_in_prog", 12'o7000, 0, 0, 0, 0, 1,   0, 0, 0, 0);
      add("cif",         12'o6212, 1, 0, 0, 0, 0,   0, 1, 0, 0);
      add("cif_done",    12'o7000, 0, 1, 0, 0, 0,   0, 1, 0, 0);
      add("jmp_clr",     12'o7000, 0, 0, 1, 0, 0,   0, 0, 0, 0);
      add("cdif",        12'o6223, 1, 0, 0, 0, 0,   0, 1, 0, 0);
      add("dev30_ign",   12'o6301, 1, 0, 0, 0, 0,   0, 1, 0, 0);
      add("dev10_ion",   12'o6101, 1, 0, 0, 0, 0,   0, 1, 0, 0);
      add("dev10_done1", 12'o7000, 0, 1, 0, 0, 0,   0, 1, 0, 0);
      add("dev10_done2", 12'o7000, 0, 1, 0, 0, 0,   0, 1, 0, 0);
      add("no_strobe",   12'o6001, 0, 0, 0, 0, 0,   0, 1, 0, 0);
      add("ion3",        12'o6001, 1, 0, 0, 0, 0,   0, 1, 0, 0);
      add("ion3_done1",  12'o7000, 0, 1, 0, 0, 0,   0, 1, 0, 0);
      add("ion3_done2",  12'o7000, 0, 1, 0, 0, 0,   1, 1, 0, 0);
      add("caf",         12'o6007, 1, 0, 0, 0, 0,   0, 0, 0, 1);
      add("caf_after",   12'o7000, 0, 0, 0, 0, 0,   0, 0, 0, 0);
      add("rtf_l1",      12'o6005, 1, 0, 0, 1, 0,   0, 0, 0, 0);
      add("rtf_done1",   12'o7000, 0, 1, 0, 0, 0,   0, 0, 0, 0);
      add("rtf_done2",   12'o7000, 0, 1, 0, 0, 0,   1, 0, 0, 0);
      add("sgt",         12'o6006, 1, 0, 0, 0, 0,   1, 0, 0, 0);
      add("rtf_l0",      12'o6005, 1, 0, 0, 0, 0,   0, 0, 0, 0);
      add("ion_vs_prog", 12'o6001, 1, 0, 0, 0, 1,   0, 0, 0, 0);
      add("prio_done1",  12'o7000, 0, 1, 0, 0, 0,   0, 0, 0, 0);
      add("prio_done2",  12'o7000, 0, 1, 0, 0, 0,   0, 0, 0, 0);
      add("cif_vs_jmp",  12'o6212, 1, 0, 1, 0, 0,   0, 1, 0, 0);

      idle();
      irq   = '0;
      reset = 1'b0;
      #100;
      check("rst_ena",  int_ena, 0);
      check("rst_inh",  int_inh, 0);
      check("rst_req",  int_req, 0);
      check("rst_skip", skip, 0);
      check("rst_caf",  caf, 0);
      reset = 1'b1;
      tick();

      // Synchroniser latency: exactly SYNC_FF edges to assert and to deassert.
      irq = 8'h01;
      for (int i = 1; i <= SYNC_FF; i++) begin
         tick();
         check($sformatf("irq_up_%0d", i), int_req, (i == SYNC_FF));
      end
      irq = '0;
      for (int i = 1; i <= SYNC_FF; i++) begin
         tick();
         check($sformatf("irq_dn_%0d", i), int_req, (i != SYNC_FF));
      end

      foreach (vecs[k]) begin
         instruction = vecs[k].instr;
         iot_strobe  = vecs[k].strobe;
         instr_done  = vecs[k].done;
         jmp_exec    = vecs[k].jmp;
         ac_link_in  = vecs[k].link;
         int_in_prog = vecs[k].inprog;
         tick();
         check({vecs[k].name, ".ena"},  int_ena, vecs[k].ena);
         check({vecs[k].name, ".inh"},  int_inh, vecs[k].inh);
         check({vecs[k].name, ".skip"}, skip,    vecs[k].skp);
         check({vecs[k].name, ".caf"},  caf,     vecs[k].cf);
      end
      idle();
      tick();

      // SRQ with a live request, then SRQ after it drops.
      irq = 8'h80;
      tick(); tick();
      check("srq_req_up", int_req, 1);
      instruction = 12'o6003; iot_strobe = 1'b1;
      tick();
      check("srq_skip", skip, 1);
      idle();
      tick();
      check("srq_skip_1cyc", skip, 0);
      irq = '0;
      tick(); tick();
      instruction = 12'o6003; iot_strobe = 1'b1;
      tick();
      check("srq_noskip", skip, 0);
      idle();

      // Reset in DLY must leave no pending enable behind.
      instruction = 12'o6001; iot_strobe = 1'b1;
      tick();
      idle(); instr_done = 1'b1;
      tick();
      instr_done = 1'b0;
      #2 reset = 1'b0;
      #1 check("rst_dly_ena", int_ena, 0);
      #10 reset = 1'b1;
      instr_done = 1'b1;
      tick();
      check("post_rst_done1", int_ena, 0);
      tick();
      check("post_rst_done2", int_ena, 0);
      instr_done = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
